// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write arbiter.
// The burst-lock types are only used when FIFO_ARB_BURST_EN is defined.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCK
  } arb_state_t;

  localparam int BURST_CNT_W = 8;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: finds the first set request at or after ptr_i,
// wrapping modulo NUM_REQ, and returns its index and one-hot grant.
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic               found_o,
  output logic [IW-1:0]      idx_o,
  output logic [NUM_REQ-1:0] grant_o
);

  int cand;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr_i) + k) % NUM_REQ;
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = IW'(cand);
      end
    end
    grant_o = found_o ? (NUM_REQ'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready requesters.
// Define FIFO_ARB_BURST_EN to let a grant hold for up to MAX_BURST consecutive words.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int DWIDTH    = 8,
  parameter  int MAX_BURST = 4,
  localparam int IW        = $clog2(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      srst_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DWIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic                      fifo_full_i,
  input  logic                      fifo_almost_full_i,
  output logic                      fifo_wrreq_o,
  output logic [DWIDTH-1:0]         fifo_data_o,
  output logic [IW-1:0]             grant_idx_o
);

  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $error("fifo_wr_arbiter: NUM_REQ must be 2..16");
  end
  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
    $error("fifo_wr_arbiter: MAX_BURST must be 1..255");
  end

  function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
    return (p == IW'(NUM_REQ - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [IW-1:0]      ptr_q;
  logic               wrreq_q;
  logic [DWIDTH-1:0]  data_q;
  logic [IW-1:0]      gidx_q;
  logic [NUM_REQ-1:0] req_eligible;
  logic               found;
  logic [IW-1:0]      sel_idx;
  logic [NUM_REQ-1:0] sel_grant;
  logic               stall;
  logic               xfer;

  // Almost-full stops new handshakes early enough to cover the registered write path.
  assign stall = fifo_full_i | fifo_almost_full_i;

`ifdef FIFO_ARB_BURST_EN
  arb_state_t             state_q;
  logic [IW-1:0]          lock_idx_q;
  logic [BURST_CNT_W-1:0] cnt_q;

  assign req_eligible = (state_q == ARB_LOCK) ? (req_valid_i & (NUM_REQ'(1) << lock_idx_q))
                                              : req_valid_i;
`else
  assign req_eligible = req_valid_i;
`endif

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i   (req_eligible),
    .ptr_i   (ptr_q),
    .found_o (found),
    .idx_o   (sel_idx),
    .grant_o (sel_grant)
  );

  assign xfer        = found & ~stall & ~srst_i;
  assign req_ready_o = xfer ? sel_grant : '0;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      ptr_q   <= '0;
      wrreq_q <= 1'b0;
      data_q  <= '0;
      gidx_q  <= '0;
`ifdef FIFO_ARB_BURST_EN
      state_q    <= ARB_IDLE;
      lock_idx_q <= '0;
      cnt_q      <= '0;
`endif
    end else begin
      wrreq_q <= xfer;
      if (xfer) begin
        data_q <= req_data_i[sel_idx*DWIDTH +: DWIDTH];
        gidx_q <= sel_idx;
        ptr_q  <= ptr_inc(sel_idx);
      end
`ifdef FIFO_ARB_BURST_EN
      case (state_q)
        ARB_IDLE: begin
          if (xfer && MAX_BURST > 1) begin
            state_q    <= ARB_LOCK;
            lock_idx_q <= sel_idx;
            cnt_q      <= BURST_CNT_W'(1);
          end
        end
        ARB_LOCK: begin
          if (xfer) begin
            if (cnt_q + 1'b1 == BURST_CNT_W'(MAX_BURST)) begin
              state_q <= ARB_IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else if (!stall && !req_valid_i[lock_idx_q]) begin
            // Locked requester went idle: give up the rest of its burst.
            state_q <= ARB_IDLE;
            ptr_q   <= ptr_inc(lock_idx_q);
            cnt_q   <= '0;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
`endif
    end
  end

  assign fifo_wrreq_o = wrreq_q;
  assign fifo_data_o  = data_q;
  assign grant_idx_o  = gidx_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter against a behavioural round-robin model,
// covering both the default build and FIFO_ARB_BURST_EN.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;
`ifdef FIFO_ARB_BURST_EN
  localparam int MB = 3;
  localparam bit BURST = 1'b1;
`else
  localparam int MB = 1;
  localparam bit BURST = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            srst;
  logic [N-1:0]    valid;
  logic [N*DW-1:0] data;
  logic [N-1:0]    ready;
  logic            full, af;
  logic            wrreq;
  logic [DW-1:0]   fdata;
  logic [IW-1:0]   gidx;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .DWIDTH(DW), .MAX_BURST(MB)) dut (
    .clk_i              (clk),
    .srst_i             (srst),
    .req_valid_i        (valid),
    .req_data_i         (data),
    .req_ready_o        (ready),
    .fifo_full_i        (full),
    .fifo_almost_full_i (af),
    .fifo_wrreq_o       (wrreq),
    .fifo_data_o        (fdata),
    .grant_idx_o        (gidx)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int            m_ptr  = 0;
  bit            m_lock = 0;
  int            m_lidx = 0;
  int            m_cnt  = 0;
  bit            e_wr   = 0;
  logic [DW-1:0] e_data = '0;
  int            e_gidx = 0;
  logic [DW-1:0] sb_q[N][$];
  int            wait_cnt[N];

  function automatic int model_sel();
    int c;
    for (int k = 0; k < N; k++) begin
      c = (m_ptr + k) % N;
      if (!(m_lock && c != m_lidx) && valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic step(output logic [N-1:0] hs);
    logic [N-1:0]  er;
    logic [N-1:0]  vhs;
    logic          st, fhs;
    int            s;
    logic [DW-1:0] dsel;
    int            worst;
    #1;
    s  = model_sel();
    st = full | af;
    er = (srst || st || s < 0) ? '0 : (N'(1) << s);
    n_tests++;
    if (ready !== er) begin
      n_fail++;
      $display("FAIL ready: got %b expected %b", ready, er);
    end
    hs   = er;
    vhs  = valid;
    fhs  = full;
    dsel = '0;
    if (er != 0) begin
      dsel = data[s*DW +: DW];
      sb_q[s].push_back(dsel);
    end
    @(posedge clk);
    if (srst) begin
      m_ptr = 0; m_lock = 0; m_cnt = 0; e_wr = 0; e_data = '0; e_gidx = 0;
      for (int i = 0; i < N; i++) begin
        sb_q[i].delete();
        wait_cnt[i] = 0;
      end
    end else if (er != 0) begin
      e_wr = 1; e_data = dsel; e_gidx = s; m_ptr = (s + 1) % N;
      if (BURST) begin
        if (!m_lock) begin
          if (MB > 1) begin m_lock = 1; m_lidx = s; m_cnt = 1; end
        end else begin
          m_cnt++;
          if (m_cnt == MB) m_lock = 0;
        end
      end
    end else begin
      e_wr = 0;
      if (m_lock && !st && !valid[m_lidx]) begin
        m_lock = 0;
        m_ptr  = (m_lidx + 1) % N;
      end
    end
    #1;
    n_tests++;
    if (wrreq !== e_wr || fdata !== e_data || gidx !== IW'(e_gidx)) begin
      n_fail++;
      $display("FAIL outputs: got wr=%b data=%h idx=%0d expected wr=%b data=%h idx=%0d",
               wrreq, fdata, gidx, e_wr, e_data, e_gidx);
    end
    n_tests++;
    if (wrreq === 1'b1 && fhs === 1'b1) begin
      n_fail++;
      $display("FAIL full_write: got wrreq=1 after handshake with full=1, expected 0");
    end
    if (e_wr && !srst) begin
      n_tests++;
      if (sb_q[e_gidx].size() == 0) begin
        n_fail++;
        $display("FAIL order: got write from req %0d with no pending word, expected none", e_gidx);
      end else if (fdata !== sb_q[e_gidx][0]) begin
        n_fail++;
        $display("FAIL order: got %h expected %h (req %0d)", fdata, sb_q[e_gidx][0], e_gidx);
        void'(sb_q[e_gidx].pop_front());
      end else begin
        void'(sb_q[e_gidx].pop_front());
      end
      worst = 0;
      for (int i = 0; i < N; i++) begin
        if (i == e_gidx || !vhs[i]) wait_cnt[i] = 0;
        else wait_cnt[i]++;
        if (wait_cnt[i] > worst) worst = wait_cnt[i];
      end
      n_tests++;
      if (worst > N * MB) begin
        n_fail++;
        $display("FAIL starve: got wait of %0d grants, limit %0d", worst, N * MB);
      end
    end
  endtask

  task automatic set_all_valid();
    valid = '1;
    for (int i = 0; i < N; i++) data[i*DW +: DW] = 8'hA0 + 8'(i);
  endtask

  task automatic do_reset();
    logic [N-1:0] hs;
    srst = 1'b1;
    step(hs);
    srst = 1'b0;
  endtask

  task automatic test_reset();
    logic [N-1:0] hs;
    full = 0; af = 0; srst = 1'b1;
    set_all_valid();
    step(hs);
    step(hs);
    n_tests++;
    if (wrreq !== 1'b0 || fdata !== '0 || gidx !== '0 || ready !== '0) begin
      n_fail++;
      $display("FAIL reset: got wr=%b data=%h idx=%0d ready=%b expected all zero",
               wrreq, fdata, gidx, ready);
    end
    srst = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [N-1:0]  hs;
    logic [DW-1:0] ex;
    do_reset();
    set_all_valid();
    for (int k = 0; k < 12; k++) begin
      step(hs);
      ex = 8'hA0 + 8'((k / MB) % N);
      n_tests++;
      if (wrreq !== 1'b1 || fdata !== ex || gidx !== IW'((k / MB) % N)) begin
        n_fail++;
        $display("FAIL round_robin[%0d]: got wr=%b data=%h idx=%0d expected wr=1 data=%h",
                 k, wrreq, fdata, gidx, ex);
      end
    end
  endtask

  task automatic test_single_req();
    logic [N-1:0] hs;
    do_reset();
    set_all_valid();
    valid = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      step(hs);
      n_tests++;
      if (wrreq !== 1'b1 || gidx !== IW'(2)) begin
        n_fail++;
        $display("FAIL single_req[%0d]: got wr=%b idx=%0d expected wr=1 idx=2", k, wrreq, gidx);
      end
    end
    set_all_valid();
`ifndef FIFO_ARB_BURST_EN
    #1;
    n_tests++;
    if (ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL single_req_next: got ready=%b expected 1000", ready);
    end
`endif
    step(hs);
    step(hs);
  endtask

  task automatic test_stall();
    logic [N-1:0]  hs;
    logic [DW-1:0] ex;
    int            k;
    do_reset();
    set_all_valid();
    k = 0;
    repeat (2) begin step(hs); k++; end
    af = 1'b1;
    for (int j = 0; j < 5; j++) begin
      step(hs);
      n_tests++;
      if (wrreq !== 1'b0 || ready !== '0) begin
        n_fail++;
        $display("FAIL stall[%0d]: got wr=%b ready=%b expected 0 and 0", j, wrreq, ready);
      end
    end
    af = 1'b0;
    repeat (6) begin
      step(hs);
      ex = 8'hA0 + 8'((k / MB) % N);
      n_tests++;
      if (wrreq !== 1'b1 || fdata !== ex) begin
        n_fail++;
        $display("FAIL stall_resume[%0d]: got wr=%b data=%h expected wr=1 data=%h",
                 k, wrreq, fdata, ex);
      end
      k++;
    end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] hs;
    do_reset();
    set_all_valid();
    valid = 4'b0010;
    step(hs);
    srst = 1'b1;
    set_all_valid();
    step(hs);
    n_tests++;
    if (wrreq !== 1'b0 || gidx !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got wr=%b idx=%0d expected wr=0 idx=0", wrreq, gidx);
    end
    srst = 1'b0;
    #1;
    n_tests++;
    if (ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_mid_grant: got ready=%b expected 0001", ready);
    end
    step(hs);
  endtask

`ifdef FIFO_ARB_BURST_EN
  task automatic test_burst_release();
    logic [N-1:0] hs;
    do_reset();
    set_all_valid();
    repeat (4) step(hs);
    valid = 4'b1101;
    step(hs);
    #1;
    n_tests++;
    if (ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL burst_release: got ready=%b expected 0100", ready);
    end
    step(hs);
  endtask
`endif

  task automatic test_random();
    logic [N-1:0] hs;
    do_reset();
    hs = '0;
    valid = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!(valid[i] && !hs[i])) begin
          valid[i] = ($urandom_range(0, 99) < 55);
          data[i*DW +: DW] = DW'($urandom);
        end
      end
      full = ($urandom_range(0, 99) < 8);
      af   = ($urandom_range(0, 99) < 12);
      srst = ($urandom_range(0, 999) == 0);
      step(hs);
    end
    srst = 1'b0;
  endtask

  initial begin
    srst = 1'b1; valid = '0; data = '0; full = 1'b0; af = 1'b0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    test_reset();
    test_round_robin();
    test_single_req();
    test_stall();
    test_reset_mid();
`ifdef FIFO_ARB_BURST_EN
    test_burst_release();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares the single write port of one `fifo` instance among NUM_REQ requesters.
- Each requester uses a valid/ready handshake.
- The arbiter applies backpressure from the FIFO's full and almost-full flags and drives registered `wrreq`/`data` into the FIFO.
- It sits directly in front of `fifo` `data_i`/`wrreq_i` in multi-producer designs.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DWIDTH, 8, data width; must match the FIFO's DWIDTH.
- MAX_BURST, 4, maximum consecutive words per grant (used only with FIFO_ARB_BURST_EN; 1..255).

Ports:
- clk_i  input  1  clock, all logic on posedge.
- srst_i  input  1  synchronous reset, active-high.
- req_valid_i  input  NUM_REQ  per-requester data valid.
- req_data_i  input  NUM_REQ*DWIDTH  packed requester data; requester i occupies bits [i*DWIDTH +: DWIDTH].
- req_ready_o  output  NUM_REQ  per-requester ready, one-hot or zero.
- fifo_full_i  input  1  FIFO `full_o`.
- fifo_almost_full_i  input  1  FIFO `almost_full_o`.
- fifo_wrreq_o  output  1  registered write request to the FIFO.
- fifo_data_o  output  DWIDTH  registered write data to the FIFO.
- grant_idx_o  output  $clog2(NUM_REQ)  index of the last accepted requester (debug/status).

Behaviour:
- Clock and reset: one clock, clk_i; reset srst_i is synchronous, active-high.
- Reset values:
  - fifo_wrreq_o=0, fifo_data_o=0, grant_idx_o=0.
  - Round-robin pointer ptr=0.
  - req_ready_o forced to 0 while srst_i=1.
- Stall: stall = fifo_full_i | fifo_almost_full_i.
  - Almost-full is the stop threshold because the write path has 1 registered cycle plus any registering at the FIFO's top level.
  - Integrator sets ALMOST_FULL_VALUE so that at least 3 free entries remain.
- Selection:
  - Combinational, when not stalled.
  - sel = first i with req_valid_i[i]=1, searching ptr, ptr+1, ..., wrapping modulo NUM_REQ.
  - req_ready_o = onehot(sel) if any valid and !stall, else 0.
- Transfer: occurs on a cycle where req_valid_i[i] & req_ready_o[i].
  - Next cycle: fifo_wrreq_o=1, fifo_data_o=req_data_i[sel], grant_idx_o=sel.
  - ptr <= (sel+1) mod NUM_REQ; wrap from NUM_REQ-1 goes to 0.
- No transfer (no valid, or stall): fifo_wrreq_o=0 next cycle; fifo_data_o holds; ptr unchanged.
- Latency: 1 cycle from handshake to fifo_wrreq_o.
- Throughput: 1 word per cycle maximum.
- Ready does not depend on fifo_wrreq_o. Valid must not depend on ready (AXI-style rule); data must stay stable while valid=1 and ready=0.
- A stall asserted in the same cycle as a valid request gives no transfer; the request is retried later with the same priority.
- Reset mid-operation: an in-flight registered write is discarded (fifo_wrreq_o=0 after reset); ptr returns to 0.

Optional Feature:
- Macro: FIFO_ARB_BURST_EN.
- When defined, the block has a 2-state FSM, IDLE and LOCK, plus an 8-bit burst counter.
  - IDLE→LOCK on a transfer when MAX_BURST>1; counter=1.
  - In LOCK, only the locked requester can be selected; each transfer increments the counter.
  - LOCK→IDLE (with ptr=locked+1) on either of:
    - a transfer that brings the counter to MAX_BURST;
    - a cycle where the locked requester's valid=0 and the block is not stalled.
  - A stall holds LOCK and the counter unchanged.
  - Reset → IDLE, counter=0.
- When undefined, there is no FSM, MAX_BURST is ignored and each grant is one word.

Decomposition:
- Package fifo_arb_pkg holds:
  - the arb_state_t enum {ARB_IDLE, ARB_LOCK};
  - the BURST_CNT_W=8 constant.
- Sub-module rr_pick (combinational): inputs req vector and ptr; outputs found flag, index and one-hot grant. It is parameterised on NUM_REQ and reused for the lock-masked request vector.

Test Plan:
- NUM_REQ=4, all valid held, data 8'hA0+i, no stall → fifo writes A0,A1,A2,A3,A0,... on consecutive cycles; grant_idx_o cycles 0,1,2,3,0.
- Only req 2 valid → every cycle ready[2]=1; writes continuous; ptr stays 3 and req 3 has priority next when it becomes valid.
- almost_full_i=1 for 5 cycles with all valid → req_ready_o=0 and fifo_wrreq_o=0 from the cycle after stall rise; resumes at the pointer where it stopped, no word lost or duplicated.
- srst_i pulsed while req 1 is transferring → fifo_wrreq_o=0 and ptr=0 next cycle; the first grant after reset goes to req 0 if valid.
- With FIFO_ARB_BURST_EN, MAX_BURST=3, all valid → writes A0,A0,A0,A1,A1,A1,...; req 1 dropping valid after 1 word releases the lock, and the next grant goes to req 2.
- Scoreboard: random valid/stall for 10k cycles → per-requester ordering preserved; no write while fifo_full_i was 1 at handshake; no requester starved beyond NUM_REQ grants (×MAX_BURST with burst enabled).
